// File: rtl/latch_wr_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// latch_wr_ctrl_pkg : shared FSM encoding and parameter defaults
// Rev 1.0
// ============================================================================
package latch_wr_ctrl_pkg;

  localparam int c_nreq_default    = 4;
  localparam int c_nlat_default    = 4;
  localparam int c_dw_default      = 8;
  localparam int c_clr_cyc_default = 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    STROBE = 3'd2,
    HOLD   = 3'd3,
    CLR    = 3'd4
  } state_t;

  // Index width that stays legal (>= 1 bit) for single-entry configurations.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/latch_wr_ctrl_rr_arbiter.sv
`default_nettype none
// ============================================================================
// rr_arbiter : combinational round-robin pick, first set req at/after ptr
// Rev 1.0
// ============================================================================
module rr_arbiter
  import latch_wr_ctrl_pkg::*;
#(
  parameter int NREQ = c_nreq_default,
  parameter int IW   = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  logic [2*NREQ-1:0] w_rot;

  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int k);
    int s;
    s = int'(p) + k;
    if (s >= NREQ) s = s - NREQ;
    return IW'(s);
  endfunction

  // Doubling the vector makes the rotate a plain shift; bit 0 is then req[ptr].
  assign w_rot = {req, req} >> ptr;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) begin
        gnt_valid = 1'b1;
        gnt_idx   = wrap_add(ptr, k);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/latch_wr_ctrl.sv
`default_nettype none
// ============================================================================
// latch_wr_ctrl : arbitrated write sequencer for an external D-latch bank
// Rev 1.0
// ============================================================================
module latch_wr_ctrl
  import latch_wr_ctrl_pkg::*;
#(
  parameter int NREQ    = c_nreq_default,
  parameter int NLAT    = c_nlat_default,
  parameter int DW      = c_dw_default,
  parameter int CLR_CYC = c_clr_cyc_default,
  localparam int AW     = clog2_min1(NLAT),
  localparam int IW     = clog2_min1(NREQ)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] addr,
  input  logic [NREQ*DW-1:0] wdata,
  output logic [NREQ-1:0]  ack,
  input  logic             clr,
  output logic [DW-1:0]    lat_d,
  output logic [NLAT-1:0]  lat_en,
  output logic             lat_rstn,
  output logic             busy,
  output logic [IW-1:0]    gnt_id
);

  localparam int                CW         = clog2_min1(CLR_CYC);
  localparam logic [CW-1:0]     c_clr_last = CW'(CLR_CYC - 1);
  localparam logic [NLAT-1:0]   c_en_one   = NLAT'(1);
  localparam logic [NREQ-1:0]   c_ack_one  = NREQ'(1);

  state_t          r_state;
  logic [IW-1:0]   r_rr_ptr;
  logic            r_clr_pend;
  logic [AW-1:0]   r_addr;
  logic [CW-1:0]   r_clr_cnt;

  logic            w_gnt_valid;
  logic [IW-1:0]   w_gnt_idx;
  logic [IW-1:0]   w_ptr_next;
  logic [AW-1:0]   w_addr_arr [NREQ];
  logic [DW-1:0]   w_data_arr [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_slice
    assign w_addr_arr[i] = addr[i*AW +: AW];
    assign w_data_arr[i] = wdata[i*DW +: DW];
  end

  rr_arbiter #(
    .NREQ (NREQ),
    .IW   (IW)
  ) u_arb (
    .req       (req),
    .ptr       (r_rr_ptr),
    .gnt_valid (w_gnt_valid),
    .gnt_idx   (w_gnt_idx)
  );

  assign w_ptr_next = (w_gnt_idx == IW'(NREQ - 1)) ? '0 : w_gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= IDLE;
      r_rr_ptr   <= '0;
      r_clr_pend <= 1'b0;
      r_addr     <= '0;
      r_clr_cnt  <= '0;
      ack        <= '0;
      lat_d      <= '0;
      lat_en     <= '0;
      lat_rstn   <= 1'b0;
      busy       <= 1'b0;
      gnt_id     <= '0;
    end else begin
      ack    <= '0;
      lat_en <= '0;
      if (clr && (r_state != IDLE)) r_clr_pend <= 1'b1;

      case (r_state)
        IDLE: begin
          if (clr || r_clr_pend) begin
            // Clear outranks any pending write; arbitration state is left alone.
            r_state    <= CLR;
            r_clr_pend <= 1'b0;
            r_clr_cnt  <= c_clr_last;
            lat_rstn   <= 1'b0;
            busy       <= 1'b1;
          end else if (w_gnt_valid) begin
            r_state  <= SETUP;
            r_addr   <= w_addr_arr[w_gnt_idx];
            lat_d    <= w_data_arr[w_gnt_idx];
            gnt_id   <= w_gnt_idx;
            r_rr_ptr <= w_ptr_next;
            lat_rstn <= 1'b1;
            busy     <= 1'b1;
          end else begin
            lat_rstn <= 1'b1;
          end
        end
        SETUP: begin
          r_state <= STROBE;
          lat_en  <= c_en_one << r_addr;
        end
        STROBE: begin
          r_state <= HOLD;
          ack     <= c_ack_one << gnt_id;
        end
        HOLD: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        CLR: begin
          if (r_clr_cnt == '0) begin
            r_state  <= IDLE;
            lat_rstn <= 1'b1;
            busy     <= 1'b0;
          end else begin
            r_clr_cnt <= r_clr_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_latch_wr_ctrl.sv
`default_nettype none
// ============================================================================
// tb_latch_wr_ctrl : directed bench with a behavioural latch bank
// Rev 1.0
// ============================================================================
module tb_latch_wr_ctrl;

  localparam int NREQ = 4;
  localparam int NLAT = 4;
  localparam int DW   = 8;
  localparam int AW   = 2;
  localparam int IW   = 2;

  logic                 clk = 1'b0;
  logic                 rstn = 1'b0;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*AW-1:0]   addr = '0;
  logic [NREQ*DW-1:0]   wdata = '0;
  logic                 clr = 1'b0;
  logic [NREQ-1:0]      ack;
  logic [DW-1:0]        lat_d;
  logic [NLAT-1:0]      lat_en;
  logic                 lat_rstn;
  logic                 busy;
  logic [IW-1:0]        gnt_id;
  logic [DW-1:0]        bank [NLAT];
  logic                 mon_en = 1'b0;
  int                   n_checks = 0;
  int                   n_errors = 0;

  latch_wr_ctrl #(.NREQ(NREQ), .NLAT(NLAT), .DW(DW), .CLR_CYC(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req      (req),
    .addr     (addr),
    .wdata    (wdata),
    .ack      (ack),
    .clr      (clr),
    .lat_d    (lat_d),
    .lat_en   (lat_en),
    .lat_rstn (lat_rstn),
    .busy     (busy),
    .gnt_id   (gnt_id)
  );

  always #5 clk = ~clk;

  always_latch begin
    for (int i = 0; i < NLAT; i++) begin
      if (!lat_rstn)     bank[i] <= '0;
      else if (lat_en[i]) bank[i] <= lat_d;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    if (obs !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr[i*AW +: AW]  = a;
    wdata[i*DW +: DW] = d;
  endtask

  // Expects the grantees ids[0..n-1] in order; each requester drops req the cycle after its ack.
  task automatic run_grants(input int n, input logic [3:0][1:0] ids);
    logic [NREQ-1:0] drop;
    drop = '0;
    for (int c = 1; c <= 4 * n; c++) begin
      step();
      req  = req & ~drop;
      drop = '0;
      if (c % 4 == 1) chk("rr_gnt", 32'(gnt_id), 32'(ids[(c-1)/4]));
      if (c % 4 == 3) chk("rr_ack", 32'(ack), 32'(1) << ids[c/4]);
      else            chk("rr_noack", 32'(ack), 32'h0);
      drop = ack;
    end
    chk("rr_idle_busy", 32'(busy), 32'h0);
  endtask

  always @(negedge clk) begin
    if (mon_en && rstn) begin
      chk("en_onehot0", 32'($onehot0(lat_en)), 32'h1);
      if (!lat_rstn) chk("en_in_clr", 32'(lat_en), 32'h0);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset values
    step(); step();
    chk("rst_en", 32'(lat_en), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_gnt", 32'(gnt_id), 32'h0);
    chk("rst_d", 32'(lat_d), 32'h0);
    chk("rst_lrstn", 32'(lat_rstn), 32'h0);
    rstn = 1'b1;
    step();
    chk("rel_lrstn", 32'(lat_rstn), 32'h1);
    mon_en = 1'b1;

    // Single write: requester 0 -> latch 2
    set_slot(0, 2'd2, 8'hA5);
    req = 4'b0001;
    step();
    chk("sw_setup_en", 32'(lat_en), 32'h0);
    chk("sw_setup_d", 32'(lat_d), 32'hA5);
    chk("sw_setup_busy", 32'(busy), 32'h1);
    step();
    chk("sw_strobe_en", 32'(lat_en), 32'h4);
    chk("sw_strobe_ack", 32'(ack), 32'h0);
    step();
    chk("sw_hold_en", 32'(lat_en), 32'h0);
    chk("sw_hold_ack", 32'(ack), 32'h1);
    chk("sw_lat2", 32'(bank[2]), 32'hA5);
    chk("sw_lat0", 32'(bank[0]), 32'h0);
    chk("sw_lat3", 32'(bank[3]), 32'h0);
    step();
    req = '0;
    chk("sw_idle_ack", 32'(ack), 32'h0);
    chk("sw_idle_busy", 32'(busy), 32'h0);

    // Reset during STROBE aborts the write
    set_slot(1, 2'd1, 8'hEE);
    req = 4'b0010;
    step();
    chk("mr_gnt", 32'(gnt_id), 32'h1);
    step();
    chk("mr_strobe_en", 32'(lat_en), 32'h2);
    rstn = 1'b0;
    #1;
    chk("mr_async_en", 32'(lat_en), 32'h0);
    chk("mr_lrstn", 32'(lat_rstn), 32'h0);
    chk("mr_busy", 32'(busy), 32'h0);
    req = '0;
    step();
    chk("mr_noack", 32'(ack), 32'h0);
    step();
    rstn = 1'b1;
    step();
    chk("mr_rel_lrstn", 32'(lat_rstn), 32'h1);
    chk("mr_rel_busy", 32'(busy), 32'h0);
    chk("mr_lat1", 32'(bank[1]), 32'h0);

    // Round-robin with all four requesting; pointer must have restarted at 0
    for (int i = 0; i < NREQ; i++) set_slot(i, AW'(i), 8'(8'h10 + i));
    req = 4'b1111;
    run_grants(4, {2'd3, 2'd2, 2'd1, 2'd0});
    for (int i = 0; i < NLAT; i++) chk("rr_lat", 32'(bank[i]), 32'(8'h10 + i));

    set_slot(0, 2'd1, 8'h5A);
    set_slot(3, 2'd3, 8'hC3);
    req = 4'b1001;
    run_grants(2, {2'd0, 2'd0, 2'd3, 2'd0});
    chk("rr2_lat1", 32'(bank[1]), 32'h5A);
    chk("rr2_lat3", 32'(bank[3]), 32'hC3);

    // Clear and request together: clear first, then the write
    set_slot(1, 2'd0, 8'h77);
    clr = 1'b1;
    req = 4'b0010;
    step();
    clr = 1'b0;
    chk("cp_lrstn0", 32'(lat_rstn), 32'h0);
    chk("cp_busy", 32'(busy), 32'h1);
    chk("cp_gnt_kept", 32'(gnt_id), 32'h3);
    step();
    chk("cp_lrstn1", 32'(lat_rstn), 32'h0);
    chk("cp_cleared", 32'(bank[0]), 32'h0);
    step();
    chk("cp_exit_lrstn", 32'(lat_rstn), 32'h1);
    chk("cp_exit_busy", 32'(busy), 32'h0);
    step();
    chk("cp_gnt", 32'(gnt_id), 32'h1);
    step();
    chk("cp_en", 32'(lat_en), 32'h1);
    chk("cp_noack", 32'(ack), 32'h0);
    step();
    chk("cp_ack", 32'(ack), 32'h2);
    step();
    req = '0;
    chk("cp_lat0", 32'(bank[0]), 32'h77);

    // Clear pulse during STROBE: write finishes, then clear follows
    set_slot(2, 2'd1, 8'h3C);
    req = 4'b0100;
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk("cb_ack", 32'(ack), 32'h4);
    chk("cb_lat1", 32'(bank[1]), 32'h3C);
    step();
    req = '0;
    chk("cb_idle_busy", 32'(busy), 32'h0);
    step();
    chk("cb_clr_lrstn", 32'(lat_rstn), 32'h0);
    chk("cb_clr_busy", 32'(busy), 32'h1);
    chk("cb_lat1_zero", 32'(bank[1]), 32'h0);
    chk("cb_lat0_zero", 32'(bank[0]), 32'h0);
    step();
    chk("cb_clr2_lrstn", 32'(lat_rstn), 32'h0);
    step();
    chk("cb_exit_lrstn", 32'(lat_rstn), 32'h1);
    chk("cb_exit_ack", 32'(ack), 32'h0);

    // Request withdrawn during SETUP still completes
    set_slot(0, 2'd3, 8'h99);
    req = 4'b0001;
    step();
    req = '0;
    chk("ab_gnt", 32'(gnt_id), 32'h0);
    step();
    chk("ab_en", 32'(lat_en), 32'h8);
    step();
    chk("ab_ack", 32'(ack), 32'h1);
    chk("ab_lat3", 32'(bank[3]), 32'h99);
    step();
    chk("ab_idle_ack", 32'(ack), 32'h0);
    chk("ab_idle_busy", 32'(busy), 32'h0);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
